// File: rtl/encoder_8to3_rr_arbiter.sv
// Round-robin arbiter for 8 requesters sharing one downstream resource.
// Registers a one-hot grant; the binary index and valid flag are an
// 8-to-3 encode of that register, so they can never disagree with it.
// Grants are separated by one idle cycle. A hold limit stops one requester
// from monopolising the resource while others are waiting.
//
// Handshake: req[i] is a level held until served; a grant to i is visible on
// gnt for at least one cycle and ends when req[i] drops, when done pulses
// while granted, or when the hold limit expires with another req pending.
// gnt returns to zero for exactly one cycle before the next grant.
module encoder_8to3_rr_arbiter #(
  parameter int MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_vld,
  output logic       state_dbg
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Last hold count value at which the hold limit may release the grant.
  localparam logic [7:0] HOLD_LAST = (MAX_HOLD == 0) ? 8'd0 : 8'(MAX_HOLD - 1);

  state_t     state;
  logic [2:0] ptr;
  logic [7:0] hold_cnt;

  logic [2:0] win_idx;
  logic       win_found;
  logic       rel_req;
  logic       rel_done;
  logic       rel_hold;
  logic       rel;

  // Round-robin scan starting at ptr: first requester found wins.
  always_comb begin
    logic [2:0] cand;
    cand      = '0;
    win_idx   = '0;
    win_found = 1'b0;
    for (int k = 0; k < 8; k++) begin
      cand = ptr + 3'(k);
      if (!win_found && req[cand]) begin
        win_idx   = cand;
        win_found = 1'b1;
      end
    end
  end

  // 8-to-3 encoder of the registered one-hot grant.
  always_comb begin
    gnt_idx[0] = gnt[1] | gnt[3] | gnt[5] | gnt[7];
    gnt_idx[1] = gnt[2] | gnt[3] | gnt[6] | gnt[7];
    gnt_idx[2] = gnt[4] | gnt[5] | gnt[6] | gnt[7];
    gnt_vld    = |gnt;
  end

  // Release conditions while granted; any combination is a single release.
  always_comb begin
    rel_req  = !req[gnt_idx];
    rel_done = done;
    rel_hold = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST) &&
               ((req & ~gnt) != 8'd0);
    rel      = rel_req || rel_done || rel_hold;
  end

  assign state_dbg = (state == GRANT);

  // FSM: arbitrate in IDLE, hold or release in GRANT; grant register is the output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      gnt      <= 8'd0;
      ptr      <= 3'd0;
      hold_cnt <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (win_found) begin
            state    <= GRANT;
            gnt      <= 8'd1 << win_idx;
            hold_cnt <= 8'd0;
          end
        end
        GRANT: begin
          if (rel) begin
            state    <= IDLE;
            gnt      <= 8'd0;
            ptr      <= gnt_idx + 3'd1;
            hold_cnt <= 8'd0;
          end else if (hold_cnt != 8'hFF) begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
        default: begin
          state    <= IDLE;
          gnt      <= 8'd0;
          hold_cnt <= 8'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_encoder_8to3_rr_arbiter.sv
// Directed bench for encoder_8to3_rr_arbiter (MAX_HOLD = 4).
module tb_encoder_8to3_rr_arbiter;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_vld;
  logic       state_dbg;

  int tests_run;
  int tests_failed;

  typedef struct {
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] idx;
    logic       vld;
  } vec_t;

  vec_t vecs[$];

  encoder_8to3_rr_arbiter #(.MAX_HOLD(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_vld   (gnt_vld),
    .state_dbg (state_dbg)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req   = 8'h00;
    done  = 1'b0;
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
  endtask

  // Scoreboard helpers
  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic check_out(input string name, input logic [7:0] eg, input logic [2:0] ei, input logic ev);
    check({name, ".gnt"}, gnt, eg);
    check({name, ".idx"}, {5'd0, gnt_idx}, {5'd0, ei});
    check({name, ".vld"}, {7'd0, gnt_vld}, {7'd0, ev});
    check({name, ".state"}, {7'd0, state_dbg}, {7'd0, ev});
  endtask

  task automatic add_vec(input logic [7:0] r, input logic d, input logic [7:0] g, input logic [2:0] i, input logic v);
    vec_t x;
    x.req = r; x.done = d; x.gnt = g; x.idx = i; x.vld = v;
    vecs.push_back(x);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;

    // Vector table, applied from reset (ptr=0).
    // Full rotation with done one cycle after each grant: idx 0..7 then 0.
    for (int i = 0; i < 9; i++) begin
      add_vec(8'hFF, 1'b0, 8'd1 << (i % 8), 3'(i % 8), 1'b1);
      add_vec(8'hFF, 1'b1, 8'h00, 3'd0, 1'b0);
    end
    // ptr=1: single request, then drop it.
    add_vec(8'h04, 1'b0, 8'h04, 3'd2, 1'b1);
    add_vec(8'h00, 1'b0, 8'h00, 3'd0, 1'b0);
    add_vec(8'h00, 1'b0, 8'h00, 3'd0, 1'b0);
    // ptr=3: req 4 and 7 -> 4; hold one cycle; done -> ptr=5 -> 7.
    add_vec(8'h90, 1'b0, 8'h10, 3'd4, 1'b1);
    add_vec(8'h90, 1'b0, 8'h10, 3'd4, 1'b1);
    add_vec(8'h90, 1'b1, 8'h00, 3'd0, 1'b0);
    add_vec(8'h90, 1'b0, 8'h80, 3'd7, 1'b1);
    add_vec(8'h90, 1'b1, 8'h00, 3'd0, 1'b0);
    // ptr wrapped to 0: req 1 and 7 -> 1; release -> ptr=2; done in IDLE ignored.
    add_vec(8'h82, 1'b0, 8'h02, 3'd1, 1'b1);
    add_vec(8'h82, 1'b1, 8'h00, 3'd0, 1'b0);
    add_vec(8'h00, 1'b1, 8'h00, 3'd0, 1'b0);
    add_vec(8'h82, 1'b0, 8'h80, 3'd7, 1'b1);
    add_vec(8'h00, 1'b0, 8'h00, 3'd0, 1'b0);

    // Reset held with all requests active: outputs stay zero.
    rst_n = 1'b0;
    req   = 8'hFF;
    done  = 1'b0;
    #1;
    check_out("rst_async", 8'h00, 3'd0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      step();
      check_out("rst_hold", 8'h00, 3'd0, 1'b0);
    end
    rst_n = 1'b1;
    step();
    check_out("rst_first_arb", 8'h01, 3'd0, 1'b1);

    // Table-driven vectors
    do_reset();
    foreach (vecs[n]) begin
      req  = vecs[n].req;
      done = vecs[n].done;
      step();
      check_out($sformatf("vec%0d", n), vecs[n].gnt, vecs[n].idx, vecs[n].vld);
    end
    done = 1'b0;

    // Hold limit alternates two persistent requesters.
    do_reset();
    req = 8'h03;
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 4; c++) begin
        step();
        check_out($sformatf("hold_r%0d_c%0d", r, c), (r == 0) ? 8'h01 : 8'h02, 3'(r), 1'b1);
      end
      step();
      check_out($sformatf("hold_bubble%0d", r), 8'h00, 3'd0, 1'b0);
    end
    step();
    check_out("hold_back_to_0", 8'h01, 3'd0, 1'b1);

    // Lone requester is never cut off by the hold limit.
    do_reset();
    req = 8'h01;
    step();
    check_out("lone_grant", 8'h01, 3'd0, 1'b1);
    for (int c = 0; c < 24; c++) begin
      step();
      check_out($sformatf("lone_c%0d", c), 8'h01, 3'd0, 1'b1);
    end
    // done and req drop together: one release, ptr advances to 1 only.
    done = 1'b1;
    req  = 8'h00;
    step();
    check_out("dual_release", 8'h00, 3'd0, 1'b0);
    done = 1'b0;
    req  = 8'h03;
    step();
    check_out("dual_ptr1", 8'h02, 3'd1, 1'b1);
    req = 8'h00;
    step();
    check_out("dual_drop", 8'h00, 3'd0, 1'b0);

    // ptr=2 here; grant 5, then reset mid-cycle clears outputs and ptr.
    req = 8'h20;
    step();
    check_out("mid_grant5", 8'h20, 3'd5, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_out("mid_rst_async", 8'h00, 3'd0, 1'b0);
    #1;
    rst_n = 1'b1;
    req   = 8'h21;
    step();
    check_out("mid_rst_ptr0", 8'h01, 3'd0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
